mem_responder: RTL

Memory-side responder for the CPU's instruction and data request ports. It accepts instruction-read and data-read/write requests, arbitrates between them (data first), and drives a single RAM port through a handshake on `ramstate`. It returns one-cycle `ihit`/`dhit` pulses with registered load data, and aborts stalled transactions with an error response after a bounded wait. It sits between the request unit/datapath and the RAM model.

---
 rtl/mem_responder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the CPU instruction and data ports.
// Arbitrates data over instruction requests, drives one RAM port through the
// ramstate handshake, returns one-cycle hit pulses with registered load data,
// and aborts an access with an error response after TIMEOUT wait cycles.
module mem_responder #(
  parameter int WORD_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              ihit,
  output logic              dhit,
  output logic [WORD_W-1:0] iload,
  output logic [WORD_W-1:0] dload,
  output logic              memerr,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DACC  = 3'd1,
    IACC  = 3'd2,
    DRESP = 3'd3,
    IRESP = 3'd4
  } state_t;

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TO_LIMIT  = CNT_W'(TIMEOUT);
  localparam logic [1:0]        RS_ACCESS = 2'd2;
  localparam logic [1:0]        RS_ERROR  = 2'd3;
  localparam logic [WORD_W-1:0] BAD_WORD  = WORD_W'(32'hBAD1BAD1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   store_q, store_d;
  logic                wr_q, wr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [WORD_W-1:0]   iload_q, iload_d;
  logic [WORD_W-1:0]   dload_q, dload_d;
  logic [CNT_W-1:0]    cnt_inc_s;
  logic                is_iacc_s;

  assign cnt_inc_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  assign is_iacc_s = (state_q == IACC);

  // Next-state logic: request latching, access handshake, abort path.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    store_d = store_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    iload_d = iload_q;
    dload_d = dload_q;
    case (state_q)
      IDLE: begin
        if (dREN || dWEN) begin
          // Data wins over a simultaneous instruction request.
          addr_d  = daddr;
          store_d = dstore;
          wr_d    = dWEN;
          cnt_d   = '0;
          state_d = DACC;
        end else if (iREN) begin
          addr_d  = iaddr;
          wr_d    = 1'b0;
          cnt_d   = '0;
          state_d = IACC;
        end else begin
          state_d = IDLE;
        end
      end
      DACC, IACC: begin
        if (ramstate == RS_ACCESS) begin
          err_d = 1'b0;
          if (is_iacc_s) begin
            iload_d = ramload;
          end else if (!wr_q) begin
            dload_d = ramload;
          end else begin
            dload_d = dload_q;
          end
          state_d = is_iacc_s ? IRESP : DRESP;
        end else if ((ramstate == RS_ERROR) || (cnt_inc_s == TO_LIMIT)) begin
          // RAM error or wait budget exhausted: complete with an error word.
          err_d = 1'b1;
          if (is_iacc_s) begin
            iload_d = BAD_WORD;
          end else if (!wr_q) begin
            dload_d = BAD_WORD;
          end else begin
            dload_d = dload_q;
          end
          state_d = is_iacc_s ? IRESP : DRESP;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      DRESP, IRESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      store_q <= '0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      iload_q <= '0;
      dload_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      iload_q <= iload_d;
      dload_q <= dload_d;
    end
  end

  // Outputs decode the registered state and latched operation only.
  assign ramREN   = is_iacc_s || ((state_q == DACC) && !wr_q);
  assign ramWEN   = (state_q == DACC) && wr_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;
  assign ihit     = (state_q == IRESP);
  assign dhit     = (state_q == DRESP);
  assign memerr   = err_q && ((state_q == IRESP) || (state_q == DRESP));
  assign iload    = iload_q;
  assign dload    = dload_q;

endmodule
